// File: rtl/store_data_aligner_pkg.sv
// Shared RV32I store encodings, aligner FSM states and byte-enable constants.
package rv32i_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/store_data_aligner_lane_gen.sv
// Combinational lane generator: store type, byte offset and rs2 data to an
// 8-lane enable/data window spanning the addressed word and the next one.
module store_lane_gen
    import rv32i_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [7:0]  be8_o,
    output logic [63:0] d64_o,
    output logic        illegal_o,
    output logic        crosses_o
);

    logic [3:0]  base_be;
    logic [31:0] masked;

    always_comb begin
        base_be   = '0;
        masked    = '0;
        illegal_o = 1'b0;
        case (type_i)
            F3_SB: begin
                base_be = BE_BYTE;
                masked  = {24'h0, data_i[7:0]};
            end
            F3_SH: begin
                base_be = BE_HALF;
                masked  = {16'h0, data_i[15:0]};
            end
            F3_SW: begin
                base_be = BE_WORD;
                masked  = data_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign be8_o     = {4'b0000, base_be} << off_i;
    assign d64_o     = {32'h0, masked} << {off_i, 3'b000};
    assign crosses_o = |be8_o[7:4];

endmodule

// File: rtl/store_data_aligner.sv
// RV32I store data aligner: lane-positions SB/SH/SW onto a 32-bit write port.
// MISALIGNED_SPLIT_EN: when defined, word-crossing stores go out as two beats.
module store_data_aligner
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_type,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        rsp_valid,
    output logic        rsp_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        be8;
    logic [63:0]       d64;
    logic              illegal;
    logic              crosses;
    logic              timeout_hit;

`ifdef MISALIGNED_SPLIT_EN
    logic [3:0]        hi_be_q, hi_be_d;
    logic [31:0]       hi_wdata_q, hi_wdata_d;
    logic              crosses_q, crosses_d;
`else
    logic              unused_hi_lanes;
    assign unused_hi_lanes = ^{be8[7:4], d64[63:32]};
`endif

    store_lane_gen u_lane_gen (
        .type_i    (req_type),
        .off_i     (req_addr[1:0]),
        .data_i    (req_data),
        .be8_o     (be8),
        .d64_o     (d64),
        .illegal_o (illegal),
        .crosses_o (crosses)
    );

    // Counter holds the number of wait cycles already spent on the current beat.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt_q) == TIMEOUT_CYC - 32'd1);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rsp_err_d   = 1'b0;
        cnt_d       = cnt_q;
`ifdef MISALIGNED_SPLIT_EN
        hi_be_d     = hi_be_q;
        hi_wdata_d  = hi_wdata_q;
        crosses_d   = crosses_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end
`ifndef MISALIGNED_SPLIT_EN
                    else if (crosses) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end
`endif
                    else begin
                        state_d     = BEAT0;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = be8[3:0];
                        mem_wdata_d = d64[31:0];
                        cnt_d       = '0;
`ifdef MISALIGNED_SPLIT_EN
                        hi_be_d     = be8[7:4];
                        hi_wdata_d  = d64[63:32];
                        crosses_d   = crosses;
`endif
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (mem_ready) begin
                    state_d = RESP;
`ifdef MISALIGNED_SPLIT_EN
                    if (state_q == BEAT0 && crosses_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_be_d    = hi_be_q;
                        mem_wdata_d = hi_wdata_q;
                        cnt_d       = '0;
                    end
`endif
                end else if (timeout_hit) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef MISALIGNED_SPLIT_EN
            hi_be_q     <= '0;
            hi_wdata_q  <= '0;
            crosses_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
`ifdef MISALIGNED_SPLIT_EN
            hi_be_q     <= hi_be_d;
            hi_wdata_q  <= hi_wdata_d;
            crosses_q   <= crosses_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q == BEAT0) || (state_q == BEAT1);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed table-driven bench for store_data_aligner (TIMEOUT_CYC=4);
// expectations follow MISALIGNED_SPLIT_EN when it is defined.
module tb_store_data_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_type;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        rsp_valid;
    logic        rsp_err;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    store_data_aligner #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_type  (req_type),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
        int          stall;    // wait cycles before each beat is accepted
        logic        err;
        int          nb;       // beats accepted
        int          rsp_cyc;  // cycles after accept edge until rsp_valid
        int          mv_cyc;   // cycles with mem_valid high
        logic [31:0] a0;
        logic [3:0]  b0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] w1;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          rsp_cyc = 0;
        int          mv_cyc = 0;
        int          nb = 0;
        int          waited = 0;
        logic        rsp_err_s = 1'b0;
        logic        rr_bad = 1'b0;
        logic        hold_bad = 1'b0;
        logic        be0_bad = 1'b0;
        logic        prev_stall = 1'b0;
        logic [31:0] pa = '0;
        logic [31:0] pw = '0;
        logic [3:0]  pb = '0;
        logic [31:0] ba [2];
        logic [31:0] bw [2];
        logic [3:0]  bb [2];
        string       tag;
        tag = $sformatf("v%0d", idx);
        for (int k = 0; k < 2; k++) begin
            ba[k] = '0; bw[k] = '0; bb[k] = '0;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_type  = v.typ;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            if (req_ready) rr_bad = 1'b1;
            if (mem_valid) begin
                mv_cyc++;
                if (mem_be == 4'b0000) be0_bad = 1'b1;
                if (prev_stall && ({mem_addr, mem_be, mem_wdata} !== {pa, pb, pw})) hold_bad = 1'b1;
                pa = mem_addr; pb = mem_be; pw = mem_wdata;
                if (waited >= v.stall) begin
                    mem_ready = 1'b1;
                    if (nb < 2) begin
                        ba[nb] = mem_addr; bb[nb] = mem_be; bw[nb] = mem_wdata;
                    end
                    nb++;
                    waited = 0;
                    prev_stall = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    waited++;
                    prev_stall = 1'b1;
                end
            end else begin
                mem_ready = 1'b0;
                prev_stall = 1'b0;
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                rsp_err_s = rsp_err;
                break;
            end
        end
        mem_ready = 1'b0;
        chk({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(v.rsp_cyc));
        chk({tag, "_rsp_err"}, 32'(rsp_err_s), 32'(v.err));
        chk({tag, "_beats"}, 32'(nb), 32'(v.nb));
        chk({tag, "_mem_valid_cycles"}, 32'(mv_cyc), 32'(v.mv_cyc));
        chk({tag, "_req_ready_busy"}, 32'(rr_bad), 32'd0);
        chk({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
        chk({tag, "_be_nonzero"}, 32'(be0_bad), 32'd0);
        if (v.nb >= 1) begin
            chk({tag, "_b0_addr"}, ba[0], v.a0);
            chk({tag, "_b0_be"}, 32'(bb[0]), 32'(v.b0));
            chk({tag, "_b0_wdata"}, bw[0], v.w0);
        end
        if (v.nb >= 2) begin
            chk({tag, "_b1_addr"}, ba[1], v.a1);
            chk({tag, "_b1_be"}, 32'(bb[1]), 32'(v.b1));
            chk({tag, "_b1_wdata"}, bw[1], v.w1);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({pfx, "_mem_addr"}, mem_addr, 32'h0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({pfx, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic bad;
        vecs[0] = '{32'h0000_1003, 32'hAABB_CC5A, 3'b000, 0, 1'b0, 1, 2, 1,
                    32'h0000_1000, 4'b1000, 32'h5A00_0000, 32'h0, 4'h0, 32'h0};
`ifdef MISALIGNED_SPLIT_EN
        vecs[1] = '{32'h0000_2002, 32'h1122_3344, 3'b010, 0, 1'b0, 2, 3, 2,
                    32'h0000_2000, 4'b1100, 32'h3344_0000, 32'h0000_2004, 4'b0011, 32'h0000_1122};
`else
        vecs[1] = '{32'h0000_2002, 32'h1122_3344, 3'b010, 0, 1'b1, 0, 1, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
`endif
        vecs[2] = '{32'h0000_0010, 32'h0000_BEEF, 3'b001, 3, 1'b0, 1, 5, 4,
                    32'h0000_0010, 4'b0011, 32'h0000_BEEF, 32'h0, 4'h0, 32'h0};
        vecs[3] = '{32'h0000_0020, 32'h1234_5678, 3'b011, 0, 1'b1, 0, 1, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[4] = '{32'h0000_0400, 32'hDEAD_BEEF, 3'b010, 0, 1'b0, 1, 2, 1,
                    32'h0000_0400, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0};
        vecs[5] = '{32'h0000_0101, 32'h1234_ABCD, 3'b001, 0, 1'b0, 1, 2, 1,
                    32'h0000_0100, 4'b0110, 32'h00AB_CD00, 32'h0, 4'h0, 32'h0};
`ifdef MISALIGNED_SPLIT_EN
        vecs[6] = '{32'h0000_0103, 32'hCAFE_1234, 3'b001, 0, 1'b0, 2, 3, 2,
                    32'h0000_0100, 4'b1000, 32'h3400_0000, 32'h0000_0104, 4'b0001, 32'h0000_0012};
`else
        vecs[6] = '{32'h0000_0103, 32'hCAFE_1234, 3'b001, 0, 1'b1, 0, 1, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
`endif
        vecs[7] = '{32'h0000_0002, 32'h1234_5678, 3'b000, 0, 1'b0, 1, 2, 1,
                    32'h0000_0000, 4'b0100, 32'h0078_0000, 32'h0, 4'h0, 32'h0};
`ifdef MISALIGNED_SPLIT_EN
        vecs[8] = '{32'hFFFF_FFFD, 32'hA1B2_C3D4, 3'b010, 0, 1'b0, 2, 3, 2,
                    32'hFFFF_FFFC, 4'b1110, 32'hB2C3_D400, 32'h0000_0000, 4'b0001, 32'h0000_00A1};
`else
        vecs[8] = '{32'hFFFF_FFFD, 32'hA1B2_C3D4, 3'b010, 0, 1'b1, 0, 1, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
`endif
        vecs[9] = '{32'h0000_0500, 32'h0102_0304, 3'b010, 100, 1'b1, 0, 5, 4,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{32'h0000_0600, 32'h5555_AAAA, 3'b111, 0, 1'b1, 0, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_type = '0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while a beat is stalled: outputs clear at the next edge and the store vanishes.
        @(negedge clk);
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0000_0030;
        req_data = 32'h1234_5678;
        req_type = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_mem_valid_before", 32'(mem_valid), 32'd1);
        chk("midrst_mem_addr_before", mem_addr, 32'h0000_0030);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || mem_valid) bad = 1'b1;
        end
        chk("midrst_no_rsp", 32'(bad), 32'd0);

        run_vec(vecs[0], 100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
